sha256_mem_responder: RTL and testbench



---
 rtl/sha256_mem_pkg.sv | 26 ++
 rtl/sha_word_ram.sv | 65 ++++++
 rtl/sha256_mem_responder.sv | 148 ++++++++++++++
 tb/tb_sha256_mem_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_mem_pkg.sv
// Shared definitions for the SHA-256 memory responder.
//   DATA_W / ADDR_W   : word width and engine/host address width
//   run_state_e       : run-control FSM states
//   DIGEST_WORDS_DEF  : engine writes expected in one run
//   in_range()        : true when an address fits in a RAM of 2**depth_log2 words
package sha256_mem_pkg;

    localparam int DATA_W           = 32;
    localparam int ADDR_W           = 16;
    localparam int DIGEST_WORDS_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ARM,
        RUN,
        FINISH
    } run_state_e;

    // Any set bit above the RAM index field makes the address out of range.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                      input int                depth_log2);
        return (addr >> depth_log2) == '0;
    endfunction

endpackage

// File: rtl/sha_word_ram.sv
// Word RAM with one write port and two registered, read-first read ports.
//   clk, reset_n      : clock and async active-low reset (output registers only)
//   we, waddr, wdata  : single write port
//   a_addr, a_ok      : port A read, every cycle; a_ok=0 forces a zero result
//   a_rdata           : port A registered read data
//   b_en, b_addr, b_ok: port B read, only when b_en; b_ok=0 forces a zero result
//   b_rdata           : port B registered read data, held between reads
module sha_word_ram
    import sha256_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] a_addr,
    input  logic                  a_ok,
    output logic [DATA_W-1:0]     a_rdata,
    input  logic                  b_en,
    input  logic [DEPTH_LOG2-1:0] b_addr,
    input  logic                  b_ok,
    output logic [DATA_W-1:0]     b_rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] a_rdata_d, a_rdata_q;
    logic [DATA_W-1:0] b_rdata_d, b_rdata_q;

    // Reads sample the array before this edge's write lands, so a
    // same-address read and write return the old word.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        a_rdata_d = a_ok ? mem[a_addr] : '0;
        b_rdata_d = b_rdata_q;
        if (b_en) begin
            b_rdata_d = b_ok ? mem[b_addr] : '0;
        end
    end

    // NOTE: the array has no reset; contents survive reset_n and it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/sha256_mem_responder.sv
// Memory-side responder for the SHA-256 engine's memory master port.
//   clk, reset_n                      : clock, async active-low reset
//   eng_we/eng_addr/eng_wdata/eng_rdata : engine port, 1-cycle registered reads
//   eng_start, eng_done               : launch pulse / engine idle indication
//   host_valid/host_ready/host_we/host_addr/host_wdata : host requests
//   host_rsp_valid, host_rdata        : host read response, one cycle after accept
//   go, busy, complete                : run control and status
//   wr_count, wr_ok, addr_err         : run write count, digest check, range error
module sha256_mem_responder
    import sha256_mem_pkg::*;
#(
    parameter int DEPTH_LOG2   = 8,
    parameter int DIGEST_WORDS = DIGEST_WORDS_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_wdata,
    output logic [DATA_W-1:0] eng_rdata,
    output logic              eng_start,
    input  logic              eng_done,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rsp_valid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              go,
    output logic              busy,
    output logic              complete,
    output logic [3:0]        wr_count,
    output logic              wr_ok,
    output logic              addr_err
);

    run_state_e  state_q, state_d;
    logic        eng_start_q, eng_start_d;
    logic        complete_q, complete_d;
    logic        host_rsp_valid_q, host_rsp_valid_d;
    logic        addr_err_q, addr_err_d;
    logic [3:0]  wr_count_q, wr_count_d;

    logic                  host_xfer, host_ok, eng_ok;
    logic                  eng_wr_en, host_wr, ram_we;
    logic [DEPTH_LOG2-1:0] ram_waddr;
    logic [DATA_W-1:0]     ram_wdata;

    assign host_ready = (state_q == IDLE);
    assign host_xfer  = host_valid & host_ready;
    assign host_ok    = in_range(host_addr, DEPTH_LOG2);
    assign eng_ok     = in_range(eng_addr, DEPTH_LOG2);

    // Host writes only happen in IDLE and engine writes only in ARM/RUN,
    // so the two never compete for the single write port.
    assign eng_wr_en = eng_we & ((state_q == ARM) | (state_q == RUN));
    assign host_wr   = host_xfer & host_we & host_ok;
    assign ram_we    = host_wr | (eng_wr_en & eng_ok);
    assign ram_waddr = host_wr ? host_addr[DEPTH_LOG2-1:0] : eng_addr[DEPTH_LOG2-1:0];
    assign ram_wdata = host_wr ? host_wdata : eng_wdata;

    always_comb begin
        state_d          = state_q;
        eng_start_d      = 1'b0;
        complete_d       = 1'b0;
        wr_count_d       = wr_count_q;
        addr_err_d       = addr_err_q;
        host_rsp_valid_d = host_xfer & ~host_we;

        // Pulse outputs are raised on the transition so they are high for
        // exactly the one cycle spent in START / FINISH.
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    state_d     = START;
                    eng_start_d = 1'b1;
                    wr_count_d  = '0;
                    addr_err_d  = 1'b0;
                end
            end
            START:  state_d = ARM;
            ARM:    if (!eng_done) state_d = RUN;
            RUN: begin
                if (eng_done) begin
                    state_d    = FINISH;
                    complete_d = 1'b1;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (eng_wr_en && eng_ok && (wr_count_q != 4'hF)) begin
            wr_count_d = wr_count_q + 4'd1;
        end

        // The engine read port is live every cycle, so its address is
        // range-checked every cycle; a new error wins over a go clear.
        if (!eng_ok || (host_xfer && !host_ok)) begin
            addr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            eng_start_q      <= 1'b0;
            complete_q       <= 1'b0;
            host_rsp_valid_q <= 1'b0;
            addr_err_q       <= 1'b0;
            wr_count_q       <= '0;
        end else begin
            state_q          <= state_d;
            eng_start_q      <= eng_start_d;
            complete_q       <= complete_d;
            host_rsp_valid_q <= host_rsp_valid_d;
            addr_err_q       <= addr_err_d;
            wr_count_q       <= wr_count_d;
        end
    end

    sha_word_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .a_addr  (eng_addr[DEPTH_LOG2-1:0]),
        .a_ok    (eng_ok),
        .a_rdata (eng_rdata),
        .b_en    (host_xfer & ~host_we),
        .b_addr  (host_addr[DEPTH_LOG2-1:0]),
        .b_ok    (host_ok),
        .b_rdata (host_rdata)
    );

    assign eng_start      = eng_start_q;
    assign complete       = complete_q;
    assign host_rsp_valid = host_rsp_valid_q;
    assign addr_err       = addr_err_q;
    assign wr_count       = wr_count_q;
    assign busy           = (state_q != IDLE);
    assign wr_ok          = complete_q & (wr_count_q == 4'(DIGEST_WORDS));

endmodule

// File: tb/tb_sha256_mem_responder.sv
// Directed testbench for sha256_mem_responder. The bench plays both the host
// and a behavioural SHA-256 engine; inputs change 1 time unit after the rising
// edge and outputs are sampled at the same point.
module tb_sha256_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        eng_we;
    logic [15:0] eng_addr;
    logic [31:0] eng_wdata;
    logic [31:0] eng_rdata;
    logic        eng_start;
    logic        eng_done;
    logic        host_valid;
    logic        host_ready;
    logic        host_we;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_rsp_valid;
    logic [31:0] host_rdata;
    logic        go;
    logic        busy;
    logic        complete;
    logic [3:0]  wr_count;
    logic        wr_ok;
    logic        addr_err;

    int vectors     = 0;
    int miscompares = 0;
    int start_cnt   = 0;
    int cmpl_cnt    = 0;

    sha256_mem_responder dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .eng_we         (eng_we),
        .eng_addr       (eng_addr),
        .eng_wdata      (eng_wdata),
        .eng_rdata      (eng_rdata),
        .eng_start      (eng_start),
        .eng_done       (eng_done),
        .host_valid     (host_valid),
        .host_ready     (host_ready),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_rsp_valid (host_rsp_valid),
        .host_rdata     (host_rdata),
        .go             (go),
        .busy           (busy),
        .complete       (complete),
        .wr_count       (wr_count),
        .wr_ok          (wr_ok),
        .addr_err       (addr_err)
    );

    always #5 clk = ~clk;

    // Pulse-width monitors: count cycles each pulse output is seen high.
    always @(negedge clk) begin
        if (eng_start) start_cnt = start_cnt + 1;
        if (complete)  cmpl_cnt  = cmpl_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_eng_rdata"},  eng_rdata,      32'h0);
        check({tag, "_host_rdata"}, host_rdata,     32'h0);
        check({tag, "_rsp_valid"},  host_rsp_valid, 32'h0);
        check({tag, "_eng_start"},  eng_start,      32'h0);
        check({tag, "_complete"},   complete,       32'h0);
        check({tag, "_wr_count"},   wr_count,       32'h0);
        check({tag, "_addr_err"},   addr_err,       32'h0);
        check({tag, "_host_ready"}, host_ready,     32'h1);
        check({tag, "_busy"},       busy,           32'h0);
    endtask

    task automatic host_write(input logic [15:0] a, input logic [31:0] d);
        host_valid = 1'b1;
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        tick();
        host_valid = 1'b0;
        host_we    = 1'b0;
    endtask

    task automatic host_read(input logic [15:0] a, output logic v, output logic [31:0] d);
        host_valid = 1'b1;
        host_we    = 1'b0;
        host_addr  = a;
        tick();
        v          = host_rsp_valid;
        d          = host_rdata;
        host_valid = 1'b0;
    endtask

    // Waits (bounded) for the complete pulse and leaves time at that cycle.
    task automatic wait_complete(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            tick();
            if (complete) seen = 1'b1;
        end
        check({tag, "_complete_seen"}, seen, 1);
    endtask

    // Full run with the behavioural engine: done drops for 20 cycles and
    // nwr words are written to base.. with data 0xC0DE0000+k.
    task automatic do_run(input string tag, input int nwr, input logic [15:0] base,
                          input logic [3:0] exp_cnt, input logic exp_ok);
        int s0 = start_cnt;
        int c0 = cmpl_cnt;
        bit ready_seen = 1'b0;
        go = 1'b1;
        tick();
        go = 1'b0;
        check({tag, "_eng_start"}, eng_start, 1);
        eng_done = 1'b0;
        tick();
        check({tag, "_start_pulse_end"}, eng_start, 0);
        for (int k = 0; k < 20; k++) begin
            eng_we    = (k < nwr);
            eng_addr  = base + 16'(k);
            eng_wdata = 32'hC0DE_0000 + 32'(k);
            tick();
            if (host_ready) ready_seen = 1'b1;
        end
        eng_we   = 1'b0;
        eng_addr = 16'h0;
        eng_done = 1'b1;
        wait_complete(tag);
        check({tag, "_wr_count"}, wr_count, 32'(exp_cnt));
        check({tag, "_wr_ok"},    wr_ok,    32'(exp_ok));
        tick();
        check({tag, "_idle"}, busy, 0);
        check({tag, "_start_pulses"},    32'(start_cnt - s0), 1);
        check({tag, "_complete_pulses"}, 32'(cmpl_cnt - c0),  1);
        check({tag, "_host_locked"},     ready_seen, 0);
    endtask

    initial begin
        logic        v;
        logic [31:0] d;
        reset_n    = 1'b0;
        eng_we     = 1'b0;
        eng_addr   = 16'h0;
        eng_wdata  = 32'h0;
        eng_done   = 1'b1;
        host_valid = 1'b0;
        host_we    = 1'b0;
        host_addr  = 16'h0;
        host_wdata = 32'h0;
        go         = 1'b0;
        tick();
        tick();
        check_reset_vals("rst");
        reset_n = 1'b1;
        tick();

        // Host write and readback.
        host_write(16'd5, 32'hDEAD_BEEF);
        host_read(16'd5, v, d);
        check("h_rsp_valid", v, 1);
        check("h_rdata",     d, 32'hDEAD_BEEF);
        tick();
        check("h_rsp_pulse_end", host_rsp_valid, 0);

        // Back-to-back engine reads, one new address per cycle.
        for (int i = 0; i < 4; i++) host_write(16'(i), 32'h10 + 32'(i));
        host_write(16'd7, 32'h77);
        for (int i = 0; i < 4; i++) begin
            eng_addr = 16'(i);
            tick();
            check($sformatf("eng_rd%0d", i), eng_rdata, 32'h10 + 32'(i));
        end
        eng_addr = 16'h0;

        // Read-during-write at address 7 while in RUN.
        go = 1'b1;
        tick();
        go       = 1'b0;
        eng_done = 1'b0;
        tick();
        tick();
        check("rdw_busy", busy, 1);
        eng_addr  = 16'd7;
        eng_we    = 1'b1;
        eng_wdata = 32'hA5A5_A5A5;
        tick();
        check("rdw_old", eng_rdata, 32'h77);
        eng_we = 1'b0;
        tick();
        check("rdw_new", eng_rdata, 32'hA5A5_A5A5);
        eng_addr = 16'h0;
        eng_done = 1'b1;
        wait_complete("rdw");
        check("rdw_wr_count", wr_count, 1);
        check("rdw_wr_ok",    wr_ok,    0);
        tick();

        // Full run with 8 digest writes, then host readback.
        do_run("run8", 8, 16'h0080, 4'd8, 1'b1);
        check("run8_count_held", wr_count, 8);
        for (int k = 0; k < 8; k++) begin
            host_read(16'h0080 + 16'(k), v, d);
            check($sformatf("run8_rb%0d", k), d, 32'hC0DE_0000 + 32'(k));
        end

        // Out-of-range host access, then go clears the sticky flag.
        host_write(16'h0100, 32'h1234_5678);
        check("oor_addr_err", addr_err, 1);
        host_read(16'h0000, v, d);
        check("oor_ram_kept", d, 32'h10);
        host_read(16'h0100, v, d);
        check("oor_rd_valid", v, 1);
        check("oor_rd_zero",  d, 32'h0);
        do_run("clr", 0, 16'h0000, 4'd0, 1'b0);
        check("clr_addr_err", addr_err, 0);

        // Reset in the middle of a run; RAM must survive.
        go = 1'b1;
        tick();
        go       = 1'b0;
        eng_done = 1'b0;
        tick();
        eng_we    = 1'b1;
        eng_addr  = 16'h0090;
        eng_wdata = 32'h5555_AAAA;
        tick();
        eng_we   = 1'b0;
        eng_addr = 16'h0;
        tick();
        check("mid_busy",     busy,     1);
        check("mid_wr_count", wr_count, 1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        tick();
        reset_n  = 1'b1;
        eng_done = 1'b1;
        tick();
        host_read(16'd5, v, d);
        check("post_rst_rsp",   v, 1);
        check("post_rst_rdata", d, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
